ssd_scan_ctrl: RTL

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ssd_scan_ctrl: 4-digit seven-segment scanner, double-buffered data  |
// | Revision: 1.0                                                       |
// +----------------------------------------------------------------------+
module ssd_scan_ctrl #(
  parameter int TICKS_ON    = 50000,
  parameter int TICKS_GUARD = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_valid,
  input  logic [1:0] wr_digit,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_done,
  output logic [3:0] an,
  output logic [7:0] ss
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  localparam logic [19:0] c_on_last    = 20'(TICKS_ON - 1);
  localparam logic [19:0] c_guard_last = 20'(TICKS_GUARD - 1);

  state_t      r_state;
  logic [1:0]  r_digit;
  logic [19:0] r_cnt;
  logic [7:0]  r_shadow [4];
  logic [7:0]  r_active [4];

  logic w_wr_fire;
  logic w_swap;

  assign w_wr_fire = wr_valid & wr_ready;
  assign w_swap    = en & (r_state == S_SWAP);

  function automatic logic [3:0] anode(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction

  // Outputs are loaded with the values of the state being entered, so an/ss
  // change only on clock edges and never pass through a decoded glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_OFF;
      r_digit    <= 2'd0;
      r_cnt      <= 20'd0;
      an         <= 4'hF;
      ss         <= 8'hFF;
      frame_done <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      an         <= 4'hF;
      ss         <= 8'hFF;
      frame_done <= 1'b0;
      wr_ready   <= 1'b1;
      if (!en) begin
        r_state <= S_OFF;
        r_digit <= 2'd0;
        r_cnt   <= 20'd0;
      end else begin
        case (r_state)
          S_OFF: begin
            r_state <= S_GUARD;
            r_digit <= 2'd0;
            r_cnt   <= 20'd0;
          end
          S_GUARD: begin
            if (r_cnt == c_guard_last) begin
              r_state <= S_ON;
              r_cnt   <= 20'd0;
              an      <= anode(r_digit);
              ss      <= r_active[r_digit];
            end else begin
              r_cnt <= r_cnt + 20'd1;
            end
          end
          S_ON: begin
            if (r_cnt == c_on_last) begin
              r_cnt <= 20'd0;
              if (r_digit == 2'd3) begin
                r_state    <= S_SWAP;
                frame_done <= 1'b1;
                wr_ready   <= 1'b0;
              end else begin
                r_state <= S_GUARD;
                r_digit <= r_digit + 2'd1;
              end
            end else begin
              r_cnt <= r_cnt + 20'd1;
              an    <= anode(r_digit);
              ss    <= r_active[r_digit];
            end
          end
          default: begin
            r_state <= S_GUARD;
            r_digit <= 2'd0;
            r_cnt   <= 20'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_shadow[i] <= 8'hFF;
    end else if (w_wr_fire) begin
      r_shadow[wr_digit] <= wr_data;
    end
  end

  // A commit landing in the swap cycle itself survives into the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_active[i] <= 8'hFF;
      commit_pending <= 1'b0;
    end else begin
      if (w_swap && commit_pending) begin
        for (int i = 0; i < 4; i++) r_active[i] <= r_shadow[i];
      end
      commit_pending <= commit | (commit_pending & ~w_swap);
    end
  end

endmodule
`default_nettype wire
